multicycle_multiplier: RTL and testbench

MULTICYCLE_MULTIPLIER -- requirements
Module: multicycle_multiplier

---
 rtl/multicycle_multiplier.sv | 120 ++++++++++++
 tb/tb_multicycle_multiplier.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_multiplier.sv
// multicycle_multiplier
//   Radix-2 shift-add multiplier that takes one multiplier bit per cycle.
//   Each operand may be treated as signed or unsigned. The product is
//   presented as a full-width two's-complement value and is held until the
//   consumer acknowledges it.
//
// Ports
//   clk_in                 : clock; all state changes on its rising edge
//   reset_in               : asynchronous reset, active low
//   multiplicand_valid_in  : multiplicand is offered
//   multiplicand_sign_in   : 1 = multiplicand is signed
//   multiplicand_in        : multiplicand, W bits
//   multiplier_valid_in    : multiplier is offered
//   multiplier_sign_in     : 1 = multiplier is signed
//   multiplier_in          : multiplier, W bits
//   issue_ack_out          : one-cycle pulse when the operand pair is accepted
//   product_valid_out      : product_out holds a result
//   product_sign_out       : 1 = the product is negative (never set for zero)
//   product_out            : product, PRODUCT_WIDTH_IN_BITS bits
//   issue_ack_in           : the consumer has taken the product
module multicycle_multiplier #(
   parameter int OPERAND_WIDTH_IN_BITS = 64,
   parameter int PRODUCT_WIDTH_IN_BITS = 2*OPERAND_WIDTH_IN_BITS
)(
   input  logic                             clk_in,
   input  logic                             reset_in,
   input  logic                             multiplicand_valid_in,
   input  logic                             multiplicand_sign_in,
   input  logic [OPERAND_WIDTH_IN_BITS-1:0] multiplicand_in,
   input  logic                             multiplier_valid_in,
   input  logic                             multiplier_sign_in,
   input  logic [OPERAND_WIDTH_IN_BITS-1:0] multiplier_in,
   output logic                             issue_ack_out,
   output logic                             product_valid_out,
   output logic                             product_sign_out,
   output logic [PRODUCT_WIDTH_IN_BITS-1:0] product_out,
   input  logic                             issue_ack_in
);

   localparam int W  = OPERAND_WIDTH_IN_BITS;
   localparam int PW = PRODUCT_WIDTH_IN_BITS;
   localparam int CW = $clog2(W+1);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state;
   logic [CW-1:0]  count;
   logic [PW-1:0]  mcand_sh;   // magnitude of the multiplicand, shifted left each iteration
   logic [W-1:0]   mplier_sh;  // magnitude of the multiplier, shifted right each iteration
   logic [PW-1:0]  acc;
   logic           res_sign;

   logic           mcand_neg;
   logic           mplier_neg;
   logic [W-1:0]   mcand_mag;
   logic [W-1:0]   mplier_mag;

   // The most-negative value negates to 2^(W-1), which still fits in an
   // unsigned W-bit magnitude.
   always_comb begin
      mcand_neg  = multiplicand_sign_in & multiplicand_in[W-1];
      mplier_neg = multiplier_sign_in & multiplier_in[W-1];
      mcand_mag  = mcand_neg  ? (~multiplicand_in + W'(1)) : multiplicand_in;
      mplier_mag = mplier_neg ? (~multiplier_in   + W'(1)) : multiplier_in;
   end

   always_ff @(posedge clk_in or negedge reset_in) begin
      if (!reset_in) begin
         state             <= IDLE;
         count             <= '0;
         mcand_sh          <= '0;
         mplier_sh         <= '0;
         acc               <= '0;
         res_sign          <= 1'b0;
         issue_ack_out     <= 1'b0;
         product_valid_out <= 1'b0;
         product_sign_out  <= 1'b0;
         product_out       <= '0;
      end else begin
         issue_ack_out <= 1'b0;
         case (state)
            IDLE: begin
               if (multiplicand_valid_in && multiplier_valid_in) begin
                  mcand_sh      <= PW'(mcand_mag);
                  mplier_sh     <= mplier_mag;
                  acc           <= '0;
                  count         <= '0;
                  res_sign      <= mcand_neg ^ mplier_neg;
                  issue_ack_out <= 1'b1;
                  state         <= BUSY;
               end
            end
            BUSY: begin
               // W iterations at count 0..W-1, then one cycle to apply the sign.
               if (count == CW'(W)) begin
                  product_out       <= res_sign ? (~acc + PW'(1)) : acc;
                  product_sign_out  <= res_sign & (acc != '0);
                  product_valid_out <= 1'b1;
                  state             <= DONE;
               end else begin
                  if (mplier_sh[0]) begin
                     acc <= acc + mcand_sh;
                  end
                  mcand_sh  <= mcand_sh << 1;
                  mplier_sh <= mplier_sh >> 1;
                  count     <= count + CW'(1);
               end
            end
            DONE: begin
               if (issue_ack_in) begin
                  product_valid_out <= 1'b0;
                  state             <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_multiplier.sv
// Directed bench for multicycle_multiplier: an 8-bit instance for the
// signed/mixed/handshake/random cases and a 64-bit instance for the wide
// unsigned case and the mid-operation reset.
module tb_multicycle_multiplier;

   logic clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   logic reset_in;

   // 8-bit instance
   logic        a8_v, a8_s, b8_v, b8_s, ack8_in;
   logic [7:0]  a8, b8;
   logic        iack8, pv8, ps8;
   logic [15:0] p8;

   // 64-bit instance
   logic         a64_v, a64_s, b64_v, b64_s, ack64_in;
   logic [63:0]  a64, b64;
   logic         iack64, pv64, ps64;
   logic [127:0] p64;

   int checks = 0;
   int errors = 0;

   int   ack_pulses8 = 0;
   int   pv_rises8   = 0;
   logic pv8_d       = 1'b0;

   multicycle_multiplier #(.OPERAND_WIDTH_IN_BITS(8)) dut8 (
      .clk_in(clk_in), .reset_in(reset_in),
      .multiplicand_valid_in(a8_v), .multiplicand_sign_in(a8_s), .multiplicand_in(a8),
      .multiplier_valid_in(b8_v), .multiplier_sign_in(b8_s), .multiplier_in(b8),
      .issue_ack_out(iack8), .product_valid_out(pv8), .product_sign_out(ps8),
      .product_out(p8), .issue_ack_in(ack8_in)
   );

   multicycle_multiplier #(.OPERAND_WIDTH_IN_BITS(64)) dut64 (
      .clk_in(clk_in), .reset_in(reset_in),
      .multiplicand_valid_in(a64_v), .multiplicand_sign_in(a64_s), .multiplicand_in(a64),
      .multiplier_valid_in(b64_v), .multiplier_sign_in(b64_s), .multiplier_in(b64),
      .issue_ack_out(iack64), .product_valid_out(pv64), .product_sign_out(ps64),
      .product_out(p64), .issue_ack_in(ack64_in)
   );

   always @(negedge clk_in) begin
      if (iack8 === 1'b1) ack_pulses8++;
      if (pv8 === 1'b1 && pv8_d !== 1'b1) pv_rises8++;
      pv8_d = pv8;
   end

   task automatic op8(input logic [7:0] a, input logic as, input logic [7:0] b, input logic bs,
                      input logic [15:0] ep, input logic es, input string nm);
      int n;
      @(negedge clk_in);
      a8 = a; a8_s = as; b8 = b; b8_s = bs; a8_v = 1'b1; b8_v = 1'b1;
      @(posedge clk_in); #1;
      checks++;
      if (iack8 !== 1'b1) begin errors++; $display("FAIL %s ack: got %b want 1", nm, iack8); end
      a8_v = 1'b0; b8_v = 1'b0;
      n = 0;
      while (pv8 !== 1'b1 && n < 50) begin @(posedge clk_in); #1; n++; end
      checks++;
      if (n != 9) begin errors++; $display("FAIL %s latency: got %0d want 9", nm, n); end
      checks++;
      if (p8 !== ep) begin errors++; $display("FAIL %s product: got %h want %h", nm, p8, ep); end
      checks++;
      if (ps8 !== es) begin errors++; $display("FAIL %s sign: got %b want %b", nm, ps8, es); end
      @(negedge clk_in); ack8_in = 1'b1;
      @(posedge clk_in); #1; ack8_in = 1'b0;
      checks++;
      if (pv8 !== 1'b0) begin errors++; $display("FAIL %s valid_fall: got %b want 0", nm, pv8); end
   endtask

   task automatic op64(input logic [63:0] a, input logic as, input logic [63:0] b, input logic bs,
                       input logic [127:0] ep, input logic es, input string nm);
      int n;
      @(negedge clk_in);
      a64 = a; a64_s = as; b64 = b; b64_s = bs; a64_v = 1'b1; b64_v = 1'b1;
      @(posedge clk_in); #1;
      checks++;
      if (iack64 !== 1'b1) begin errors++; $display("FAIL %s ack: got %b want 1", nm, iack64); end
      a64_v = 1'b0; b64_v = 1'b0;
      n = 0;
      while (pv64 !== 1'b1 && n < 200) begin @(posedge clk_in); #1; n++; end
      checks++;
      if (n != 65) begin errors++; $display("FAIL %s latency: got %0d want 65", nm, n); end
      checks++;
      if (p64 !== ep) begin errors++; $display("FAIL %s product: got %h want %h", nm, p64, ep); end
      checks++;
      if (ps64 !== es) begin errors++; $display("FAIL %s sign: got %b want %b", nm, ps64, es); end
      @(negedge clk_in); ack64_in = 1'b1;
      @(posedge clk_in); #1; ack64_in = 1'b0;
      checks++;
      if (pv64 !== 1'b0) begin errors++; $display("FAIL %s valid_fall: got %b want 0", nm, pv64); end
   endtask

   task automatic test_reset();
      int n;
      reset_in = 1'b0;
      a8_v = 1'b0; a8_s = 1'b0; b8_v = 1'b0; b8_s = 1'b0; ack8_in = 1'b0; a8 = '0; b8 = '0;
      a64_v = 1'b0; a64_s = 1'b0; b64_v = 1'b0; b64_s = 1'b0; ack64_in = 1'b0; a64 = '0; b64 = '0;
      #12;
      checks++;
      if ({iack8, pv8, ps8, p8} !== 19'd0) begin
         errors++; $display("FAIL reset8: got %b%b%b %h want all 0", iack8, pv8, ps8, p8);
      end
      checks++;
      if ({iack64, pv64, ps64} !== 3'd0 || p64 !== '0) begin
         errors++; $display("FAIL reset64: got %b%b%b %h want all 0", iack64, pv64, ps64, p64);
      end
      // Operands held valid through reset are only taken after release.
      a8 = 8'd2; b8 = 8'd3; a8_v = 1'b1; b8_v = 1'b1;
      @(posedge clk_in); #1;
      checks++;
      if (iack8 !== 1'b0) begin errors++; $display("FAIL reset_hold_ack: got %b want 0", iack8); end
      @(negedge clk_in); reset_in = 1'b1;
      @(posedge clk_in); #1;
      checks++;
      if (iack8 !== 1'b1) begin errors++; $display("FAIL first_edge_ack: got %b want 1", iack8); end
      a8_v = 1'b0; b8_v = 1'b0;
      n = 0;
      while (pv8 !== 1'b1 && n < 50) begin @(posedge clk_in); #1; n++; end
      checks++;
      if (p8 !== 16'd6 || n != 9) begin
         errors++; $display("FAIL first_op: got %h after %0d want 0006 after 9", p8, n);
      end
      @(negedge clk_in); ack8_in = 1'b1;
      @(posedge clk_in); #1; ack8_in = 1'b0;
   endtask

   task automatic test_single_valid();
      @(negedge clk_in); a8 = 8'd9; b8 = 8'd9; a8_v = 1'b1; b8_v = 1'b0;
      repeat (3) begin
         @(posedge clk_in); #1;
         checks++;
         if (iack8 !== 1'b0) begin errors++; $display("FAIL single_mcand: ack got %b want 0", iack8); end
      end
      @(negedge clk_in); a8_v = 1'b0; b8_v = 1'b1;
      repeat (3) begin
         @(posedge clk_in); #1;
         checks++;
         if (iack8 !== 1'b0) begin errors++; $display("FAIL single_mplier: ack got %b want 0", iack8); end
      end
      @(negedge clk_in); b8_v = 1'b0;
   endtask

   task automatic test_signed();
      op8(8'hFD, 1'b1, 8'h07, 1'b1, 16'hFFEB, 1'b1, "neg3x7");
      op8(8'h80, 1'b1, 8'h80, 1'b1, 16'h4000, 1'b0, "min_x_min8");
      op8(8'hFF, 1'b1, 8'hFF, 1'b1, 16'h0001, 1'b0, "neg1xneg1");
   endtask

   task automatic test_mixed();
      op8(8'hFF, 1'b0, 8'h80, 1'b1, 16'h8080, 1'b1, "u255xs_neg128");
      op8(8'hFB, 1'b1, 8'h00, 1'b1, 16'h0000, 1'b0, "neg5x0");
      op8(8'hFF, 1'b0, 8'hFF, 1'b0, 16'hFE01, 1'b0, "umax_x_umax8");
   endtask

   task automatic test_wide();
      op64(64'hFFFFFFFF00000001, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b0,
           128'hFFFFFFFEFFFFFFFF_00000001FFFFFFFE, 1'b0, "wide_unsigned");
      op64(64'h8000000000000000, 1'b1, 64'h8000000000000000, 1'b1,
           128'h4000_0000_0000_0000_0000_0000_0000_0000, 1'b0, "min_x_min64");
   endtask

   task automatic test_handshake();
      int a0;
      int n;
      a0 = ack_pulses8;
      @(negedge clk_in); a8 = 8'd12; b8 = 8'd10; a8_s = 1'b0; b8_s = 1'b0; a8_v = 1'b1; b8_v = 1'b1;
      repeat (3) @(posedge clk_in);
      // Ack while busy must be ignored.
      @(negedge clk_in); ack8_in = 1'b1;
      @(negedge clk_in); ack8_in = 1'b0;
      n = 0;
      while (pv8 !== 1'b1 && n < 50) begin @(posedge clk_in); #1; n++; end
      checks++;
      if (p8 !== 16'h0078) begin errors++; $display("FAIL hs_product: got %h want 0078", p8); end
      repeat (10) begin
         @(posedge clk_in); #1;
         checks++;
         if (p8 !== 16'h0078 || pv8 !== 1'b1) begin
            errors++; $display("FAIL hs_hold: got %h valid %b want 0078 valid 1", p8, pv8);
         end
      end
      checks++;
      if (ack_pulses8 - a0 != 1) begin
         errors++; $display("FAIL hs_ack_count: got %0d want 1", ack_pulses8 - a0);
      end
      @(negedge clk_in); a8 = 8'd3; b8 = 8'd4; ack8_in = 1'b1;
      @(posedge clk_in); #1; ack8_in = 1'b0;
      checks++;
      if (pv8 !== 1'b0 || iack8 !== 1'b0) begin
         errors++; $display("FAIL hs_release: valid %b ack %b want 0 0", pv8, iack8);
      end
      @(posedge clk_in); #1;
      checks++;
      if (iack8 !== 1'b1) begin errors++; $display("FAIL hs_next_accept: got %b want 1", iack8); end
      a8_v = 1'b0; b8_v = 1'b0;
      n = 0;
      while (pv8 !== 1'b1 && n < 50) begin @(posedge clk_in); #1; n++; end
      checks++;
      if (p8 !== 16'h000C) begin errors++; $display("FAIL hs_next_product: got %h want 000c", p8); end
      @(negedge clk_in); ack8_in = 1'b1;
      @(posedge clk_in); #1; ack8_in = 1'b0;
   endtask

   task automatic test_reset_abort();
      int seen;
      @(negedge clk_in);
      a64 = 64'h0123456789ABCDEF; b64 = 64'hFEDCBA9876543210; a64_s = 1'b0; b64_s = 1'b0;
      a64_v = 1'b1; b64_v = 1'b1;
      @(posedge clk_in); #1;
      checks++;
      if (iack64 !== 1'b1) begin errors++; $display("FAIL abort_ack: got %b want 1", iack64); end
      a64_v = 1'b0; b64_v = 1'b0;
      repeat (20) @(posedge clk_in);
      #2 reset_in = 1'b0;
      #1;
      checks++;
      if ({iack64, pv64, ps64} !== 3'd0 || p64 !== '0) begin
         errors++; $display("FAIL abort_outputs: got %b%b%b %h want all 0", iack64, pv64, ps64, p64);
      end
      @(negedge clk_in); @(negedge clk_in); reset_in = 1'b1;
      seen = 0;
      repeat (80) begin @(posedge clk_in); #1; if (pv64 === 1'b1) seen++; end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL abort_no_product: got %0d valid cycles want 0", seen); end
      op64(64'd3, 1'b0, 64'd5, 1'b0, 128'd15, 1'b0, "after_abort_3x5");
   endtask

   task automatic test_random();
      int a0, p0;
      logic [7:0] a, b;
      logic as, bs;
      logic signed [17:0] ea, eb;
      logic signed [35:0] prod;
      a0 = ack_pulses8; p0 = pv_rises8;
      for (int i = 0; i < 1000; i++) begin
         a = 8'($urandom); b = 8'($urandom);
         as = 1'(i & 1); bs = 1'((i >> 1) & 1);
         ea = {{10{as & a[7]}}, a};
         eb = {{10{bs & b[7]}}, b};
         prod = ea * eb;
         op8(a, as, b, bs, prod[15:0], prod < 0, "random");
      end
      @(negedge clk_in);
      checks++;
      if (ack_pulses8 - a0 != 1000 || pv_rises8 - p0 != 1000) begin
         errors++; $display("FAIL random_counts: acks %0d valids %0d want 1000 1000",
                            ack_pulses8 - a0, pv_rises8 - p0);
      end
   endtask

   initial begin
      test_reset();
      test_single_valid();
      test_signed();
      test_mixed();
      test_wide();
      test_handshake();
      test_reset_abort();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
